fifo_dest_router: RTL

FIFO_DEST_ROUTER -- requirements
Module: fifo_dest_router

---
 rtl/fifo_dest_router.sv | 67 ++++++
 1 files changed

// File: rtl/fifo_dest_router.sv
// fifo_dest_router: pops an upstream FIFO and pushes each word to one of four downstream FIFOs by its top two bits.
// Define ROUTER_WORD_COUNT_EN to enable the words_routed counter; otherwise words_routed is tied to 0.
module fifo_dest_router #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic                  fifo_error,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  read_enable,
  input  logic                  almost_full_0,
  input  logic                  almost_full_1,
  input  logic                  almost_full_2,
  input  logic                  almost_full_3,
  output logic                  push_0,
  output logic                  push_1,
  output logic                  push_2,
  output logic                  push_3,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            state,
  output logic [7:0]            words_routed
);
  typedef enum logic [1:0] {S_RESET, S_IDLE, S_ACTIVE, S_ERROR} state_t;
  state_t                state_q, state_d;
  logic                  rd_q, any_af, kill;
  logic [3:0]            push_q, push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  always_comb begin
    any_af      = almost_full_0 | almost_full_1 | almost_full_2 | almost_full_3;
    read_enable = (state_q == S_IDLE || state_q == S_ACTIVE) && !fifo_empty && !any_af;
    state_d     = state_q == S_RESET ? S_IDLE :
                  (state_q == S_ERROR || fifo_error) ? S_ERROR :
                  state_q == S_IDLE ? ((!fifo_empty && !any_af) ? S_ACTIVE : S_IDLE) :
                  ((fifo_empty || any_af) && !rd_q) ? S_IDLE : S_ACTIVE;
    // entering or sitting in ERROR discards whatever is in flight
    kill        = state_d == S_ERROR;
    push_d      = (rd_q && !kill) ? 4'b0001 << fifo_data[DATA_WIDTH-1 -: 2] : 4'b0000;
    data_d      = (rd_q && !kill) ? fifo_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      rd_q    <= 1'b0;
      push_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= read_enable && !kill;
      push_q  <= push_d;
      data_q  <= data_d;
    end
  end
  assign {push_3, push_2, push_1, push_0} = push_q;
  assign data_out = data_q;
  assign state    = state_q;
`ifdef ROUTER_WORD_COUNT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (|push_q) cnt_q <= cnt_q + 8'd1;
  end
  assign words_routed = cnt_q;
`else
  assign words_routed = 8'd0;
`endif
endmodule
